// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Merges the core's instruction bus (ireq/iresp) and data bus (dreq/dresp)
//   onto a single-beat memory bus (creq/cresp). One transaction is in flight
//   at a time. The data bus wins ties, but after MAX_DSTREAK consecutive data
//   grants taken while a fetch was waiting, the next grant goes to the fetch.
//
// Handshake semantics (all buses):
//   A requester raises *req_valid with stable fields and holds them until it
//   sees its *resp_data_ok pulse. addr_ok and data_ok pulse together for one
//   cycle. creq_valid stays high with constant fields until a cycle in which
//   cresp_ready && cresp_last; cresp_ready without cresp_last is a protocol
//   error: it is counted and otherwise ignored.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   ireq_* / iresp_*      instruction fetch request / response (32-bit word)
//   dreq_* / dresp_*      load/store request / response (64-bit lane)
//   creq_* / cresp_*      memory-side request / response
//   dbg_state             current FSM state (IDLE=0, BUSY=1, DONE=2)
//   dbg_proto_errs        saturating count of cresp_ready without cresp_last
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [63:0] creq_addr,
    output logic [2:0]  creq_size,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data,
    output logic [1:0]  dbg_state,
    output logic [7:0]  dbg_proto_errs
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_d_q, owner_d_d;   // 1 = data bus owns the transaction
    logic [63:0]     addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic [7:0]      strobe_q, strobe_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [7:0]      errs_q, errs_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            strobe_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            streak_q  <= '0;
            errs_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strobe_q  <= strobe_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            streak_q  <= streak_d;
            errs_q    <= errs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strobe_d  = strobe_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        streak_d  = streak_q;
        errs_d    = errs_q;

        unique case (state_q)
            IDLE: begin
                // The streak only limits the data bus while a fetch is waiting.
                if (dreq_valid && ((streak_q < MAX_S) || !ireq_valid)) begin
                    owner_d_d = 1'b1;
                    addr_d    = dreq_addr;
                    size_d    = dreq_size;
                    strobe_d  = dreq_strobe;
                    wdata_d   = dreq_data;
                    if (ireq_valid) begin
                        streak_d = (streak_q == MAX_S) ? streak_q : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                    state_d = BUSY;
                end else if (ireq_valid) begin
                    owner_d_d = 1'b0;
                    addr_d    = ireq_addr;
                    size_d    = 3'd2;
                    strobe_d  = 8'h00;
                    wdata_d   = 64'h0;
                    streak_d  = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cresp_ready) begin
                    if (cresp_last) begin
                        rdata_d = cresp_data;
                        state_d = DONE;
                    end else begin
                        errs_d = (errs_q == 8'hFF) ? errs_q : errs_q + 8'd1;
                    end
                end
            end
            DONE: begin
                // No grant here so a requester can drop or change valid.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic in_done;
    assign in_done = (state_q == DONE);

    assign creq_valid    = (state_q == BUSY);
    assign creq_is_write = |strobe_q;     // fetches latch a zero strobe
    assign creq_addr     = addr_q;
    assign creq_size     = size_q;
    assign creq_strobe   = strobe_q;
    assign creq_data     = wdata_q;

    assign iresp_addr_ok = in_done && !owner_d_q;
    assign iresp_data_ok = in_done && !owner_d_q;
    assign iresp_data    = (in_done && !owner_d_q)
                           ? (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0])
                           : 32'h0;

    assign dresp_addr_ok = in_done && owner_d_q;
    assign dresp_data_ok = in_done && owner_d_q;
    assign dresp_data    = (in_done && owner_d_q) ? rdata_q : 64'h0;

    assign dbg_state      = state_q;
    assign dbg_proto_errs = errs_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_proto_errs;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mem_bus_arbiter #(.MAX_DSTREAK(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .dbg_state(dbg_state), .dbg_proto_errs(dbg_proto_errs)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0;
    dreq_strobe = 8'h0; dreq_data = 64'h0;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'h0;
  endtask

  task automatic random_inputs();
    ireq_valid = 1'($urandom); ireq_addr = {$urandom, $urandom};
    dreq_valid = 1'($urandom); dreq_addr = {$urandom, $urandom};
    dreq_size = 3'($urandom_range(0, 3)); dreq_strobe = 8'($urandom);
    dreq_data = {$urandom, $urandom};
    cresp_ready = 1'($urandom); cresp_last = 1'($urandom);
    cresp_data = {$urandom, $urandom};
  endtask

  // Waits (bounded) for creq_valid; waited = falling edges spent with it low.
  task automatic wait_creq(output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (creq_valid === 1'b1) begin
        seen = 1'b1;
        return;
      end
      step();
      waited++;
    end
  endtask

  // Memory answers after lat idle cycles; returns at the response cycle.
  task automatic mem_beat(input int lat, input logic [63:0] d);
    for (int i = 0; i < lat; i++) step();
    cresp_ready = 1'b1; cresp_last = 1'b1; cresp_data = d;
    step();
    cresp_ready = 1'b0; cresp_last = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [248:0] outs;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      #1;
      outs = {iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok,
              dresp_data, creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe,
              creq_data, dbg_proto_errs};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h required 0", outs);
      end
      step();
    end
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (creq_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: creq_valid=%b required 0", creq_valid);
      end
    end
  endtask

  task automatic test_fetch();
    bit seen;
    int waited;
    ireq_valid = 1'b1; ireq_addr = 64'h0000_0000_8000_0004;
    step();
    wait_creq(seen, waited);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fetch_grant: creq_valid never rose");
    end
    checks++;
    if ({creq_is_write, creq_size, creq_strobe, creq_addr} !==
        {1'b0, 3'd2, 8'h00, 64'h0000_0000_8000_0004}) begin
      errors++;
      $display("FAIL fetch_creq: wr=%b size=%0d strb=%h addr=%h required 0/2/00/80000004",
               creq_is_write, creq_size, creq_strobe, creq_addr);
    end
    mem_beat(2, 64'hAAAA_BBBB_CCCC_DDDD);
    checks++;
    if ({iresp_addr_ok, iresp_data_ok, dresp_data_ok, iresp_data} !== {3'b110, 32'hAAAA_BBBB}) begin
      errors++;
      $display("FAIL fetch_resp: ok=%b%b dok=%b data=%h required 1 1 0 aaaabbbb",
               iresp_addr_ok, iresp_data_ok, dresp_data_ok, iresp_data);
    end
    ireq_valid = 1'b0;
    step();
    checks++;
    if ({iresp_data_ok, creq_valid} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_pulse: data_ok=%b creq_valid=%b required 0 0", iresp_data_ok, creq_valid);
    end
  endtask

  task automatic test_store();
    bit seen;
    int waited;
    dreq_valid = 1'b1; dreq_addr = 64'h100; dreq_size = 3'd3;
    dreq_strobe = 8'h0F; dreq_data = 64'h1122_3344_5566_7788;
    step();
    wait_creq(seen, waited);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL store_grant: creq_valid never rose");
    end
    checks++;
    if ({creq_is_write, creq_addr, creq_size, creq_strobe, creq_data} !==
        {1'b1, 64'h100, 3'd3, 8'h0F, 64'h1122_3344_5566_7788}) begin
      errors++;
      $display("FAIL store_creq: wr=%b addr=%h size=%0d strb=%h data=%h", creq_is_write,
               creq_addr, creq_size, creq_strobe, creq_data);
    end
    mem_beat(0, 64'h0);
    checks++;
    if ({dresp_addr_ok, dresp_data_ok, iresp_data_ok} !== 3'b110) begin
      errors++;
      $display("FAIL store_resp: d_ok=%b%b i_ok=%b required 1 1 0",
               dresp_addr_ok, dresp_data_ok, iresp_data_ok);
    end
    dreq_valid = 1'b0; dreq_strobe = 8'h0;
    step();
    checks++;
    if (dresp_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL store_pulse: dresp_data_ok=%b required 0", dresp_data_ok);
    end
  endtask

  task automatic test_priority();
    bit seen;
    int waited;
    bit got_d, exp_d;
    ireq_valid = 1'b1; ireq_addr = 64'h1000;
    dreq_valid = 1'b1; dreq_addr = 64'h2000; dreq_size = 3'd3; dreq_strobe = 8'h0;
    step();
    for (int g = 0; g < 10; g++) begin
      wait_creq(seen, waited);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL prio_grant%0d: creq_valid never rose", g);
      end
      got_d = (creq_addr == 64'h2000);
      exp_d = ((g % 5) != 4);
      checks++;
      if (got_d !== exp_d) begin
        errors++;
        $display("FAIL prio_order%0d: got %s required %s", g, got_d ? "D" : "I", exp_d ? "D" : "I");
      end
      if (g > 0) begin
        checks++;
        if (waited != 2) begin
          errors++;
          $display("FAIL prio_gap%0d: idle cycles %0d required 2", g, waited);
        end
      end
      mem_beat(0, {$urandom, $urandom});
    end
    clear_inputs();
    step();
  endtask

  task automatic test_drop();
    bit seen;
    int waited;
    logic [63:0] x, y;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    dreq_valid = 1'b1; dreq_addr = 64'h300; dreq_size = 3'd3; dreq_strobe = 8'h0;
    step();
    wait_creq(seen, waited);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drop_grant: creq_valid never rose");
    end
    dreq_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({creq_valid, creq_addr} !== {1'b1, 64'h300}) begin
        errors++;
        $display("FAIL drop_hold%0d: valid=%b addr=%h required 1 300", i, creq_valid, creq_addr);
      end
    end
    mem_beat(0, x);
    checks++;
    if ({dresp_data_ok, dresp_data} !== {1'b1, x}) begin
      errors++;
      $display("FAIL drop_resp: ok=%b data=%h required 1 %h", dresp_data_ok, dresp_data, x);
    end
    ireq_valid = 1'b1; ireq_addr = 64'h40;
    step();
    wait_creq(seen, waited);
    checks++;
    if (!seen || creq_addr !== 64'h40) begin
      errors++;
      $display("FAIL drop_next_grant: seen=%b addr=%h required 1 40", seen, creq_addr);
    end
    mem_beat(1, y);
    checks++;
    if ({iresp_data_ok, iresp_data} !== {1'b1, y[31:0]}) begin
      errors++;
      $display("FAIL drop_next_resp: ok=%b data=%h required 1 %h", iresp_data_ok, iresp_data, y[31:0]);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_proto_err();
    bit seen;
    int waited;
    logic [63:0] z;
    z = {$urandom, $urandom};
    dreq_valid = 1'b1; dreq_addr = 64'h500; dreq_size = 3'd2; dreq_strobe = 8'h0;
    step();
    wait_creq(seen, waited);
    cresp_ready = 1'b1; cresp_last = 1'b0; cresp_data = ~z;
    step();
    cresp_ready = 1'b0;
    checks++;
    if ({creq_valid, dresp_data_ok, dbg_proto_errs} !== {2'b10, 8'd1}) begin
      errors++;
      $display("FAIL proto_err: valid=%b dok=%b errs=%0d required 1 0 1",
               creq_valid, dresp_data_ok, dbg_proto_errs);
    end
    mem_beat(0, z);
    checks++;
    if ({dresp_data_ok, dresp_data} !== {1'b1, z}) begin
      errors++;
      $display("FAIL proto_resp: ok=%b data=%h required 1 %h", dresp_data_ok, dresp_data, z);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_busy();
    bit seen;
    int waited;
    dreq_valid = 1'b1; dreq_addr = 64'h600; dreq_size = 3'd3; dreq_strobe = 8'hFF;
    dreq_data = {$urandom, $urandom};
    step();
    wait_creq(seen, waited);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rbusy_grant: creq_valid never rose");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({creq_valid, creq_addr} !== 65'h0) begin
      errors++;
      $display("FAIL rbusy_async: valid=%b addr=%h required 0 0", creq_valid, creq_addr);
    end
    clear_inputs();
    step();
    step();
    reset = 1'b1;
    ireq_valid = 1'b1; ireq_addr = 64'h0000_0000_8000_0004;
    step();
    wait_creq(seen, waited);
    checks++;
    if (!seen || creq_addr !== 64'h0000_0000_8000_0004) begin
      errors++;
      $display("FAIL rbusy_regrant: seen=%b addr=%h required 1 80000004", seen, creq_addr);
    end
    mem_beat(0, 64'h0123_4567_89AB_CDEF);
    checks++;
    if ({iresp_data_ok, iresp_data, dbg_proto_errs} !== {1'b1, 32'h0123_4567, 8'd0}) begin
      errors++;
      $display("FAIL rbusy_resp: ok=%b data=%h errs=%0d required 1 01234567 0",
               iresp_data_ok, iresp_data, dbg_proto_errs);
    end
    clear_inputs();
    step();
  endtask

  // Cycle-level reference: the arbitration rules applied to the inputs the
  // bench is about to drive, with expected responses queued in exp_q.
  task automatic test_random();
    localparam int PH_IDLE = 0, PH_BEAT = 1, PH_RESP = 2;
    int ph = PH_IDLE;
    int streak = 0;
    int m_errs = 0;
    bit m_d = 1'b0;
    logic [63:0] m_addr = '0, m_data = '0;
    logic [2:0] m_size = '0;
    logic [7:0] m_strobe = '0;
    logic [63:0] got;
    bit exp_i, exp_d;
    for (int cyc = 0; cyc < 440; cyc++) begin
      checks++;
      if (creq_valid !== (ph == PH_BEAT)) begin
        errors++;
        $display("FAIL rnd_valid@%0d: got %b required %b", cyc, creq_valid, ph == PH_BEAT);
      end
      if (ph == PH_BEAT) begin
        checks++;
        if ({creq_is_write, creq_addr, creq_size, creq_strobe} !== {|m_strobe, m_addr, m_size, m_strobe}
            || (m_d && creq_data !== m_data)) begin
          errors++;
          $display("FAIL rnd_creq@%0d: wr=%b addr=%h size=%0d strb=%h data=%h required %b %h %0d %h %h",
                   cyc, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data,
                   |m_strobe, m_addr, m_size, m_strobe, m_data);
        end
      end
      exp_i = (ph == PH_RESP) && !m_d;
      exp_d = (ph == PH_RESP) && m_d;
      checks++;
      if ({iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok} !== {exp_i, exp_i, exp_d, exp_d}) begin
        errors++;
        $display("FAIL rnd_ok@%0d: got %b%b%b%b required %b%b%b%b", cyc, iresp_addr_ok, iresp_data_ok,
                 dresp_addr_ok, dresp_data_ok, exp_i, exp_i, exp_d, exp_d);
      end
      if (iresp_data_ok === 1'b1 || dresp_data_ok === 1'b1) begin
        got = dresp_data_ok ? dresp_data : {32'h0, iresp_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_resp@%0d: unexpected response %h", cyc, got);
        end else if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_resp@%0d: got %h required %h", cyc, got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      // requesters: the served one drops, idle ones may issue
      if (ph == PH_RESP) begin
        if (m_d) dreq_valid = 1'b0;
        else     ireq_valid = 1'b0;
      end
      if (cyc < 400 && !ireq_valid && $urandom_range(0, 2) == 0) begin
        ireq_valid = 1'b1;
        ireq_addr = {$urandom, $urandom};
      end
      if (cyc < 400 && !dreq_valid && $urandom_range(0, 2) == 0) begin
        dreq_valid = 1'b1;
        dreq_addr = {$urandom, $urandom};
        dreq_size = 3'($urandom_range(0, 3));
        dreq_strobe = $urandom_range(0, 1) ? 8'($urandom) : 8'h0;
        dreq_data = {$urandom, $urandom};
      end
      // memory
      if (ph == PH_BEAT) begin
        cresp_ready = (cyc >= 400) ? 1'b1 : 1'($urandom);
        cresp_last = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 7) != 0);
        cresp_data = {$urandom, $urandom};
      end else begin
        cresp_ready = 1'b0;
        cresp_last = 1'b0;
      end
      // reference transition for the coming rising edge
      case (ph)
        PH_IDLE: begin
          if (dreq_valid && (streak < 4 || !ireq_valid)) begin
            m_d = 1'b1; m_addr = dreq_addr; m_size = dreq_size;
            m_strobe = dreq_strobe; m_data = dreq_data;
            streak = ireq_valid ? ((streak < 4) ? streak + 1 : 4) : 0;
            ph = PH_BEAT;
          end else if (ireq_valid) begin
            m_d = 1'b0; m_addr = ireq_addr; m_size = 3'd2;
            m_strobe = 8'h0; m_data = 64'h0;
            streak = 0;
            ph = PH_BEAT;
          end
        end
        PH_BEAT: begin
          if (cresp_ready && cresp_last) begin
            if (m_d) exp_q.push_back(cresp_data);
            else     exp_q.push_back({32'h0, m_addr[2] ? cresp_data[63:32] : cresp_data[31:0]});
            ph = PH_RESP;
          end else if (cresp_ready) begin
            m_errs++;
          end
        end
        default: ph = PH_IDLE;
      endcase
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: %0d responses never returned", exp_q.size());
    end
    checks++;
    if (dbg_proto_errs !== 8'(m_errs)) begin
      errors++;
      $display("FAIL rnd_proto_errs: got %0d required %0d", dbg_proto_errs, m_errs);
    end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    reset = 1'b0;
    step();
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_drop();
    test_proto_err();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
